// File: rtl/mem_sequencer.sv
// Two-requester RAM access sequencer: round-robin arbitration between cpu and dbg,
// then MAR/MDR/RAM strobe sequencing on the shared bus.
// Optional macro MEM_SEQUENCER_TXN_COUNT_EN adds REG_OUT_MEM_SEQ, a completed-transaction counter.
module mem_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_done,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_oe,
  output logic                  MAR_in,
  output logic                  MDR_in,
  output logic                  MDR_out,
  output logic                  RAM_enable_read,
  output logic                  RAM_enable_write
`ifdef MEM_SEQUENCER_TXN_COUNT_EN
  ,
  output logic [15:0]           REG_OUT_MEM_SEQ
`endif
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds it until
  // its done pulse; req/we/addr/wdata are sampled only in IDLE, so later changes
  // (including dropping req) cannot alter or abort an accepted transaction.
  // A req still high in IDLE after done is a new request.

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD,
    S_OUT,
    S_DATA,
    S_WR,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  gnt_dbg_q, gnt_dbg_d;
  logic                  last_dbg_q, last_dbg_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic pick_dbg;
  logic any_req;

  // dbg wins only when it is alone or when cpu had the previous grant.
  assign any_req  = cpu_req | dbg_req;
  assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt_dbg_d  = gnt_dbg_q;
    last_dbg_d = last_dbg_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          we_d       = pick_dbg ? dbg_we    : cpu_we;
          addr_d     = pick_dbg ? dbg_addr  : cpu_addr;
          wdata_d    = pick_dbg ? dbg_wdata : cpu_wdata;
          gnt_dbg_d  = pick_dbg;
          last_dbg_d = pick_dbg;
          state_d    = S_ADDR;
        end
      end
      S_ADDR:  state_d = we_q ? S_DATA : S_RD;
      S_RD:    state_d = S_OUT;
      S_OUT: begin
        rdata_d = bus_in;
        state_d = S_DONE;
      end
      S_DATA:  state_d = S_WR;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt_dbg_q  <= 1'b0;
      last_dbg_q <= 1'b1;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_dbg_q  <= gnt_dbg_d;
      last_dbg_q <= last_dbg_d;
      rdata_q    <= rdata_d;
    end
  end

  // Moore decode: every strobe comes from the registered state only.
  always_comb begin
    bus_out          = '0;
    bus_oe           = 1'b0;
    MAR_in           = 1'b0;
    MDR_in           = 1'b0;
    MDR_out          = 1'b0;
    RAM_enable_read  = 1'b0;
    RAM_enable_write = 1'b0;
    cpu_done         = 1'b0;
    dbg_done         = 1'b0;
    busy             = (state_q != S_IDLE);
    case (state_q)
      S_ADDR: begin
        bus_oe  = 1'b1;
        bus_out = DATA_WIDTH'(addr_q);
        MAR_in  = 1'b1;
      end
      S_RD:   RAM_enable_read = 1'b1;
      S_OUT:  MDR_out = 1'b1;
      S_DATA: begin
        bus_oe  = 1'b1;
        bus_out = wdata_q;
        MDR_in  = 1'b1;
      end
      S_WR:   RAM_enable_write = 1'b1;
      S_DONE: begin
        cpu_done = ~gnt_dbg_q;
        dbg_done = gnt_dbg_q;
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

`ifdef MEM_SEQUENCER_TXN_COUNT_EN
  logic [15:0] txn_cnt_q, txn_cnt_d;

  // Wraps naturally from 0xFFFF to 0x0000.
  always_comb begin
    txn_cnt_d = txn_cnt_q;
    if (state_q == S_DONE) txn_cnt_d = txn_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) txn_cnt_q <= '0;
    else       txn_cnt_q <= txn_cnt_d;
  end

  assign REG_OUT_MEM_SEQ = txn_cnt_q;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: directed vector table, multi-cycle corner
// sequences, and a randomized-mix phase with a per-cycle strobe monitor.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0]  cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_done, dbg_done;
  logic [15:0] rdata, bus_in, bus_out;
  logic        busy, bus_oe;
  logic        MAR_in, MDR_in, MDR_out, RAM_enable_read, RAM_enable_write;
`ifdef MEM_SEQUENCER_TXN_COUNT_EN
  logic [15:0] REG_OUT_MEM_SEQ;
`endif

  mem_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_done(dbg_done),
    .rdata(rdata), .busy(busy), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .MDR_out(MDR_out),
    .RAM_enable_read(RAM_enable_read), .RAM_enable_write(RAM_enable_write)
`ifdef MEM_SEQUENCER_TXN_COUNT_EN
    , .REG_OUT_MEM_SEQ(REG_OUT_MEM_SEQ)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0] strb;
  assign strb = {MAR_in, MDR_in, MDR_out, RAM_enable_read, RAM_enable_write};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        mon_en = 1'b0;
  logic        rnd_en = 1'b0;
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      chk1("mon_strobe_onehot0", $onehot0(strb), 1'b1);
      chk1("mon_oe_vs_mdr_out", bus_oe & MDR_out, 1'b0);
      if (rnd_en && MDR_out) exp_q.push_back(bus_in);
    end
  end

  // ---------------- vector table ----------------
  // strb: expected {MAR_in,MDR_in,MDR_out,RAM_rd,RAM_wr} for cycles N+1..N+4, MSB first.
  localparam logic [19:0] W_STRB = {5'b10000, 5'b01000, 5'b00001, 5'b00000};
  localparam logic [19:0] R_STRB = {5'b10000, 5'b00010, 5'b00100, 5'b00000};
  localparam logic [3:0]  W_OE   = 4'b1100;
  localparam logic [3:0]  R_OE   = 4'b1000;

  typedef struct {
    logic        dbg;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rd_bus;
    logic [19:0] strb;
    logic [3:0]  oe;
    logic [15:0] exp_bus1;
    logic [15:0] exp_bus2;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] last_rd;

  task automatic drive_req(input logic d, input logic r, input logic w,
                           input logic [7:0] a, input logic [15:0] wd);
    if (d) begin
      dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = wd;
    end else begin
      cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = wd;
    end
  endtask

  // Called in an IDLE cycle (cycle N); returns in cycle N+5 (IDLE again).
  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    bus_in = 16'h5A5A;
    drive_req(v.dbg, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk16({p, "_strobes"}, {11'd0, strb}, {11'd0, v.strb[19-5*(k-1) -: 5]});
      chk1({p, "_bus_oe"}, bus_oe, v.oe[4-k]);
      chk1({p, "_busy"}, busy, 1'b1);
      chk1({p, "_cpu_done"}, cpu_done, (k == 4) && !v.dbg);
      chk1({p, "_dbg_done"}, dbg_done, (k == 4) && v.dbg);
      if (k == 1) begin
        chk16({p, "_bus_addr"}, bus_out, v.exp_bus1);
        // Scramble the request fields: they were latched at grant.
        drive_req(v.dbg, 1'b1, ~v.we, ~v.addr, ~v.wdata);
      end
      if (k == 2 && v.we) chk16({p, "_bus_wdata"}, bus_out, v.exp_bus2);
      bus_in = (k == 3) ? v.rd_bus : 16'h5A5A;
      if (k == 4) begin
        if (!v.we) begin
          chk16({p, "_rdata"}, rdata, v.exp_rdata);
          last_rd = v.exp_rdata;
        end
        drive_req(v.dbg, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
    end
    tick();
    chk1({p, "_idle_busy"}, busy, 1'b0);
    chk16({p, "_rdata_held"}, rdata, last_rd);
  endtask

  task automatic check_dones(input string nm, input logic c, input logic d);
    chk1({nm, "_cpu_done"}, cpu_done, c);
    chk1({nm, "_dbg_done"}, dbg_done, d);
  endtask

  int cpu_iss, dbg_iss, cpu_got, dbg_got, cyc;
  logic cpu_pend, dbg_pend, cpu_we_l, dbg_we_l;
  logic [15:0] exp_rd;

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    bus_in = 16'h0000;
    last_rd = 16'h0000;

    vecs[0] = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 16'h0000, W_STRB, W_OE, 16'h0012, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 8'h12, 16'h0000, 16'hBEEF, R_STRB, R_OE, 16'h0012, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, W_STRB, W_OE, 16'h00FF, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'h1234, R_STRB, R_OE, 16'h00FF, 16'h0000, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 16'hFFFF, 16'hFFFF, R_STRB, R_OE, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[5] = '{1'b1, 1'b1, 8'h00, 16'h0000, 16'hC3C3, W_STRB, W_OE, 16'h0000, 16'h0000, 16'h0000};

    tick(); tick();
    reset = 1'b0;
    // reset state
    chk16("rst_strobes", {11'd0, strb}, 16'h0000);
    chk1("rst_bus_oe", bus_oe, 1'b0);
    chk16("rst_bus_out", bus_out, 16'h0000);
    chk16("rst_rdata", rdata, 16'h0000);
    check_dones("rst", 1'b0, 1'b0);
    chk1("rst_busy", busy, 1'b0);
`ifdef MEM_SEQUENCER_TXN_COUNT_EN
    chk16("rst_txn_cnt", REG_OUT_MEM_SEQ, 16'h0000);
`endif
    mon_en = 1'b1;

    // simultaneous requests from reset: cpu, dbg, cpu, dbg
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h02; dbg_wdata = 16'h0102;
    for (int i = 1; i <= 4; i++) begin
      tick(); check_dones($sformatf("tie1_c%0d", i), i == 4, 1'b0);
    end
    cpu_req = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(); check_dones($sformatf("tie2_c%0d", i), 1'b0, i == 5);
    end
    cpu_req = 1;
    for (int i = 1; i <= 5; i++) begin
      tick(); check_dones($sformatf("tie3_c%0d", i), i == 5, 1'b0);
    end
    cpu_req = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(); check_dones($sformatf("tie4_c%0d", i), 1'b0, i == 5);
    end
    dbg_req = 0;
    tick();
    chk1("tie_end_busy", busy, 1'b0);
    last_rd = rdata === 16'hxxxx ? 16'h0000 : bus_in; // reads above captured bus_in
    last_rd = 16'h0000;

    // directed vectors
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
`ifdef MEM_SEQUENCER_TXN_COUNT_EN
    chk16("txn_cnt_after_vecs", REG_OUT_MEM_SEQ, 16'd10);
`endif

    // reset in DATA state of a write to 0x20
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 16'hCAFE;
    tick();
    chk1("rmid_mar_in", MAR_in, 1'b1);
    tick();
    chk1("rmid_in_data", MDR_in, 1'b1);
    reset = 1'b1;
    cpu_req = 0;
    tick();
    reset = 1'b0;
    chk16("rmid_strobes", {11'd0, strb}, 16'h0000);
    chk1("rmid_bus_oe", bus_oe, 1'b0);
    chk1("rmid_busy", busy, 1'b0);
    check_dones("rmid", 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("rmid_no_ram_wr", RAM_enable_write, 1'b0);
      check_dones("rmid_after", 1'b0, 1'b0);
    end
    last_rd = 16'h0000;
`ifdef MEM_SEQUENCER_TXN_COUNT_EN
    chk16("txn_cnt_after_reset", REG_OUT_MEM_SEQ, 16'h0000);
    force dut.txn_cnt_q = 16'hFFFF;
    #2;
    release dut.txn_cnt_q;
    run_vec(vecs[0], 90);
    chk16("txn_cnt_wrap", REG_OUT_MEM_SEQ, 16'h0000);
    run_vec(vecs[0], 91);
    chk16("txn_cnt_one", REG_OUT_MEM_SEQ, 16'h0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk16("txn_cnt_reset", REG_OUT_MEM_SEQ, 16'h0000);
`endif

    // random mix of 200 transactions
    cpu_iss = 0; dbg_iss = 0; cpu_got = 0; dbg_got = 0; cyc = 0;
    cpu_pend = 0; dbg_pend = 0; cpu_we_l = 0; dbg_we_l = 0;
    rnd_en = 1'b1;
    while ((cpu_iss + dbg_iss < 200 || cpu_pend || dbg_pend) && cyc < 6000) begin
      tick();
      cyc++;
      bus_in = 16'($urandom_range(0, 65535));
      if (cpu_done) begin
        chk1("rnd_cpu_done_pending", cpu_pend, 1'b1);
        cpu_pend = 0; cpu_req = 0; cpu_got++;
        if (!cpu_we_l) begin
          exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          chk16("rnd_cpu_rdata", rdata, exp_rd);
        end
      end
      if (dbg_done) begin
        chk1("rnd_dbg_done_pending", dbg_pend, 1'b1);
        dbg_pend = 0; dbg_req = 0; dbg_got++;
        if (!dbg_we_l) begin
          exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          chk16("rnd_dbg_rdata", rdata, exp_rd);
        end
      end
      if (!cpu_pend && !cpu_done && cpu_iss + dbg_iss < 200 && $urandom_range(0, 2) == 0) begin
        cpu_we_l = 1'($urandom_range(0, 1));
        drive_req(1'b0, 1'b1, cpu_we_l, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
        cpu_pend = 1; cpu_iss++;
      end
      if (!dbg_pend && !dbg_done && cpu_iss + dbg_iss < 200 && $urandom_range(0, 2) == 0) begin
        dbg_we_l = 1'($urandom_range(0, 1));
        drive_req(1'b1, 1'b1, dbg_we_l, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
        dbg_pend = 1; dbg_iss++;
      end
    end
    rnd_en = 1'b0;
    chk1("rnd_no_timeout", cyc < 6000, 1'b1);
    chk16("rnd_cpu_dones", 16'(cpu_got), 16'(cpu_iss));
    chk16("rnd_dbg_dones", 16'(dbg_got), 16'(dbg_iss));
    chk16("rnd_total", 16'(cpu_iss + dbg_iss), 16'd200);
    chk16("rnd_queue_drained", 16'(exp_q.size()), 16'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Arbitrates RAM access between two requesters: the control unit (cpu) and the debug/loader port (dbg).
- For each accepted request, sequences the MAR/MDR/RAM strobes over the shared 16-bit tri-state bus.
- Sits beside the control unit and drives MAR_in, MDR_in, MDR_out, RAM_enable_read and RAM_enable_write.
- Gives the requesters a simple req/done handshake in place of raw microcode timing.

Parameters:
- ADDR_WIDTH, 8: RAM address width; the address goes on bus bits [ADDR_WIDTH-1:0], upper bits are 0.
- DATA_WIDTH, 16: bus and data width.

Ports:
- clk  input  1  system clock (the one-shot clock at top level).
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  cpu transaction request; held until cpu_done.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_WIDTH  cpu address.
- cpu_wdata  input  DATA_WIDTH  cpu write data.
- cpu_done  output  1  one-cycle completion pulse.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_done: same as the cpu_* ports, for the debug requester.
- rdata  output  DATA_WIDTH  read data; valid while done is high, held until the next read completes.
- busy  output  1  high in every non-IDLE state.
- bus_in  input  DATA_WIDTH  current bus value.
- bus_out  output  DATA_WIDTH  value to drive onto the bus.
- bus_oe  output  1  bus drive enable; top level does bus = bus_oe ? bus_out : Z.
- MAR_in, MDR_in, MDR_out, RAM_enable_read, RAM_enable_write  output  1 each  datapath strobes.

Behaviour:
- Clocking: single clock clk; reset is synchronous and active-high.
- Reset values: state = IDLE, every strobe = 0, bus_oe = 0, bus_out = 0, rdata = 0, done outputs = 0, last_grant = dbg (so cpu wins the first tie).
- Output decoding: all strobes, bus_oe and done are Moore outputs decoded from the registered state. No output may depend combinationally on any req input.
- States: IDLE, ADDR, RD, OUT, DATA, WR, DONE.
- IDLE arbitration:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_grant (round-robin).
  - On grant, latch we, addr, wdata and the grant id, update last_grant, then go to ADDR.
  - If no req is high, stay in IDLE.
- ADDR: bus_oe = 1, bus_out = zero-extended latched addr, MAR_in = 1. Next state is RD if read, DATA if write.
- RD: RAM_enable_read = 1 (MDR captures RAM). Next state OUT.
- OUT: MDR_out = 1, bus_oe = 0. rdata <= bus_in at the clock edge. Next state DONE.
- DATA: bus_oe = 1, bus_out = latched wdata, MDR_in = 1. Next state WR.
- WR: RAM_enable_write = 1. Next state DONE.
- DONE: pulse done for the granted requester only (cpu_done or dbg_done), then go to IDLE.
- Latency: a request seen high in IDLE at cycle N gives done in cycle N+4, for both read and write.
  - Back-to-back transactions: one IDLE cycle between consecutive transactions.
- Requester rule: deassert req at the clock edge following the done cycle. A req still high in IDLE is treated as a new request.
- Request inputs are sampled only in IDLE.
  - Changes to we, addr or wdata after grant have no effect.
  - Dropping req mid-transaction does not abort it; done still pulses.
- Mutual exclusion:
  - bus_oe is high only in ADDR and DATA.
  - MDR_out is high only in OUT, so at most one bus driver is ever enabled by this block.
  - At most one strobe of {MAR_in, MDR_in, MDR_out, RAM_enable_read, RAM_enable_write} is high in any cycle.
- Reset mid-transaction: the next edge returns to IDLE with all strobes low. The transaction is lost, no done is pulsed, and the RAM write does not occur unless the WR cycle had already completed.
- Address width: addr is always zero-extended, with no wrap handling needed. addr = 2^ADDR_WIDTH - 1 is legal.

Optional Feature:
- Macro: MEM_SEQUENCER_TXN_COUNT_EN.
- When defined:
  - Adds output REG_OUT_MEM_SEQ [15:0], a count of completed transactions.
  - Increments by 1 in each DONE cycle and wraps from 0xFFFF to 0x0000.
  - Resets to 0 and is not incremented by transactions aborted by reset.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Single cpu write: cpu_req = 1, we = 1, addr = 0x12, wdata = 0xBEEF.
  - Expect MAR_in with bus = 0x0012 in cycle N+1, MDR_in with bus = 0xBEEF in N+2, RAM_enable_write in N+3, cpu_done in N+4.
  - Expect dbg_done to stay 0 throughout.
- Read-back: dbg read of addr 0x12.
  - Expect RAM_enable_read in N+2 and MDR_out in N+3 with the bench driving bus_in = 0xBEEF.
  - Expect dbg_done in N+4 with rdata = 0xBEEF, and rdata held afterwards.
- Simultaneous requests: cpu and dbg both high from reset.
  - Expect cpu granted first; after cpu_done, dbg is granted with dbg_done 5 cycles after cpu_done.
  - Repeat with both high: cpu is granted again (alternation).
- Reset mid-operation: assert reset in the DATA state of a write to 0x20.
  - Expect all strobes 0 at the next edge, state IDLE, no done pulse, and RAM_enable_write never asserted.
- Strobe exclusivity: random mix of 200 transactions from both requesters.
  - Check that at most one strobe is high each cycle.
  - Check that bus_oe and MDR_out are never high together.
  - Check that every req receives exactly one done.
- MEM_SEQUENCER_TXN_COUNT_EN: preload the counter to 0xFFFF via 65535 transactions (or force), then run one more.
  - Expect REG_OUT_MEM_SEQ = 0x0000.
  - After reset, expect 0.
